// File: rtl/modn_updn_counter_if.sv
// rtl/modn_updn_counter_if.sv - control/status signal bundle for modn_updn_counter
//
// Purpose: groups the counter's control inputs and status outputs so that a
//          driver (master) and the counter (slave) connect through one port.
// Signals:
//   en        count enable                     (master -> slave)
//   up_dn     direction, 1 = up, 0 = down      (master -> slave)
//   load      synchronous load strobe          (master -> slave)
//   load_val  value to load, WIDTH bits        (master -> slave)
//   count     registered current count         (slave -> master)
//   tc        combinational terminal count     (slave -> master)
//   wrap      registered one-cycle wrap pulse  (slave -> master)

interface modn_updn_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/modn_updn_counter.sv
// rtl/modn_updn_counter.sv - modulo-N up/down counter with load, terminal count and wrap pulse
//
// Purpose: counts 0..MODULUS-1 up or down, with a clamped synchronous load.
//          tc is combinational so that tc of one digit can drive en of the
//          next to build multi-digit counters with no glue logic.
// Parameters:
//   WIDTH    count register width in bits
//   MODULUS  number of count states, 2..2**WIDTH
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (count = 0, wrap = 0)
//   bus      modn_updn_counter_if.slave: en, up_dn, load, load_val in;
//            count, tc, wrap out
// Configuration:
//   MODN_SAT_EN  when defined, the counter saturates at the boundaries instead
//                of wrapping; tc still asserts there and wrap stays 0.

module modn_updn_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic                clk,
  input logic                rst,
  modn_updn_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_wrap_next;
  logic             w_at_top;
  logic             w_at_bottom;
  logic             w_tc;

  assign w_at_top    = (r_count == MAX_CNT);
  assign w_at_bottom = (r_count == '0);

  // Terminal count: the next enabled step in the current direction crosses
  // the boundary. Load suppresses it because load wins over counting.
  assign w_tc = bus.en & ~bus.load &
                ((bus.up_dn & w_at_top) | (~bus.up_dn & w_at_bottom));

  // Out-of-range load values are clamped so count never leaves 0..MODULUS-1.
  assign w_load_clamped = (bus.load_val > MAX_CNT) ? MAX_CNT : bus.load_val;

  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (bus.load) begin
      w_count_next = w_load_clamped;
    end else if (bus.en) begin
      if (w_tc) begin
`ifdef MODN_SAT_EN
        w_count_next = r_count;
`else
        w_count_next = bus.up_dn ? '0 : MAX_CNT;
        w_wrap_next  = 1'b1;
`endif
      end else if (bus.up_dn) begin
        w_count_next = r_count + WIDTH'(1);
      end else begin
        w_count_next = r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign bus.count = r_count;
  assign bus.tc    = w_tc;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_modn_updn_counter.sv
// tb/tb_modn_updn_counter.sv - self-checking bench for modn_updn_counter

module tb_modn_updn_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  modn_updn_counter_if #(.WIDTH(WIDTH)) u_if ();
  modn_updn_counter_if #(.WIDTH(WIDTH)) lo_if ();
  modn_updn_counter_if #(.WIDTH(WIDTH)) hi_if ();

  modn_updn_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // Two-digit decimal cascade: low digit tc drives high digit en.
  modn_updn_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_lo (
    .clk (clk),
    .rst (rst),
    .bus (lo_if.slave)
  );

  modn_updn_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_hi (
    .clk (clk),
    .rst (rst),
    .bus (hi_if.slave)
  );

  assign hi_if.en       = lo_if.tc;
  assign hi_if.up_dn    = 1'b1;
  assign hi_if.load     = 1'b0;
  assign hi_if.load_val = '0;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lv;
    logic       tc;
    logic [3:0] cnt;
    logic       wrap;
  } vec_t;

  typedef struct packed {
    logic [7:0] value;
    logic       wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(bit en, bit up, bit ld, int lv, bit tc, int cnt, bit wrap);
    vec_t v;
    v.en   = en;
    v.up   = up;
    v.ld   = ld;
    v.lv   = 4'(lv);
    v.tc   = tc;
    v.cnt  = 4'(cnt);
    v.wrap = wrap;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic up, input logic ld, input logic [3:0] lv);
    @(negedge clk);
    u_if.en       = en;
    u_if.up_dn    = up;
    u_if.load     = ld;
    u_if.load_val = lv;
  endtask

  // One clocked vector: check tc before the edge, queue the expected post-edge
  // state, then pop and compare once the edge has been taken.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    drive(v.en, v.up, v.ld, v.lv);
    #1;
    check({name, "_tc"}, 32'(u_if.tc), 32'(v.tc));
    sb_q.push_back('{value: 8'(v.cnt), wrap: v.wrap});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({name, "_count"}, 32'(u_if.count), 32'(e.value));
    check({name, "_wrap"}, 32'(u_if.wrap), 32'(e.wrap));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   hi_wraps;
    int   c;

    rst            = 1'b1;
    u_if.en        = 1'b0;
    u_if.up_dn     = 1'b1;
    u_if.load      = 1'b0;
    u_if.load_val  = '0;
    lo_if.en       = 1'b0;
    lo_if.up_dn    = 1'b1;
    lo_if.load     = 1'b0;
    lo_if.load_val = '0;

    // Reset applied before any clock edge.
    #2;
    check("rst_count", 32'(u_if.count), 32'd0);
    check("rst_wrap", 32'(u_if.wrap), 32'd0);
    check("rst_tc_idle", 32'(u_if.tc), 32'd0);
    u_if.en    = 1'b1;
    u_if.up_dn = 1'b0;
    #1;
    check("rst_tc_down", 32'(u_if.tc), 32'd1);
    u_if.en    = 1'b0;
    u_if.up_dn = 1'b1;
    @(negedge clk);
    rst = 1'b0;

`ifdef MODN_SAT_EN
    // Saturating: 15 up edges stick at 9, then 12 down edges stick at 0.
    for (int i = 0; i < 15; i++) begin
      c = (i < 9) ? i : 9;
      vecs.push_back(mk(1, 1, 0, 0, c == 9, (i + 1 < 9) ? i + 1 : 9, 0));
    end
    for (int i = 0; i < 12; i++) begin
      c = (9 - i > 0) ? 9 - i : 0;
      vecs.push_back(mk(1, 0, 0, 0, c == 0, (8 - i > 0) ? 8 - i : 0, 0));
    end
`else
    // Up through the wrap.
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 3, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 5, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 6, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 7, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 9, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 2, 0));
    // Down through the wrap.
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 0));
    // Hold.
    vecs.push_back(mk(0, 1, 0, 0, 0, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 7, 0));
    // Loads: plain, clamped, overriding an up-wrap at 9.
    vecs.push_back(mk(1, 1, 1, 3, 0, 3, 0));
    vecs.push_back(mk(1, 0, 1, 13, 0, 9, 0));
    vecs.push_back(mk(1, 1, 1, 7, 0, 7, 0));
    vecs.push_back(mk(0, 1, 1, 15, 0, 9, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    // Back-to-back wraps with a same-edge direction change.
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 1));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 9, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-count reset: load 6, step to 7, then reset between edges with en held.
    apply(mk(0, 1, 1, 6, 0, 6, 0), "mid_load6");
    apply(mk(1, 1, 0, 0, 0, 7, 0), "mid_step7");
    drive(1, 1, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(u_if.count), 32'd0);
    check("mid_rst_wrap", 32'(u_if.wrap), 32'd0);
    check("mid_rst_tc_up", 32'(u_if.tc), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_first_edge", 32'(u_if.count), 32'd1);
    check("mid_first_wrap", 32'(u_if.wrap), 32'd0);

`ifndef MODN_SAT_EN
    // Reset must clear a pending wrap pulse asynchronously.
    apply(mk(0, 1, 1, 0, 0, 0, 0), "wr_load0");
    apply(mk(1, 0, 0, 0, 1, 9, 1), "wr_down");
    drive(1, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    check("wr_rst_count", 32'(u_if.count), 32'd0);
    check("wr_rst_wrap", 32'(u_if.wrap), 32'd0);
    check("wr_rst_tc_down", 32'(u_if.tc), 32'd1);
    u_if.up_dn = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("wr_first_edge", 32'(u_if.count), 32'd1);

    // Two-digit cascade: 100 up edges from 00.
    @(negedge clk);
    u_if.en     = 1'b0;
    lo_if.en    = 1'b1;
    lo_if.up_dn = 1'b1;
    hi_wraps    = 0;
    for (int k = 0; k < 100; k++) begin
      sb_q.push_back('{value: 8'((k + 1) % 100), wrap: 1'b0});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("casc%0d", k), 32'(hi_if.count) * 10 + 32'(lo_if.count), 32'(e.value));
      if (hi_if.wrap === 1'b1) hi_wraps++;
    end
    check("casc_hi_wraps", 32'(hi_wraps), 32'd1);
    @(negedge clk);
    lo_if.en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modn_updn_counter.md
MODN_UPDN_COUNTER -- requirements
Module: modn_updn_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning count register width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 10, meaning the number of count states; legal range 2..2**WIDTH.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, count enable.
REQ-006 The block SHALL have port up_dn, input, 1, count direction: 1 = up, 0 = down.
REQ-007 The block SHALL have port load, input, 1, synchronous load strobe.
REQ-008 The block SHALL have port load_val, input, WIDTH, value to load.
REQ-009 The block SHALL have port count, output, WIDTH, registered current count.
REQ-010 The block SHALL have port tc, output, 1, combinational terminal count; high when the next enabled step crosses the boundary.
REQ-011 The block SHALL have port wrap, output, 1, registered one-cycle pulse; high in the cycle after count wraps.

Function
REQ-012 Priority per edge SHALL be: rst > load > en > hold.
REQ-013 If load=1, count SHALL take load_val if load_val <= MODULUS-1, else MODULUS-1 (clamp); en and up_dn are ignored that cycle.
REQ-014 If load=0, en=1, up_dn=1: count SHALL go to 0 when count == MODULUS-1, else to count+1.
REQ-015 If load=0, en=1, up_dn=0: count SHALL go to MODULUS-1 when count == 0, else to count-1.
REQ-016 If load=0 and en=0, count SHALL hold.
REQ-017 tc SHALL equal en & ~load & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)), with no register stage.
REQ-018 wrap SHALL be 1 on the edge following any edge where tc=1 and the count actually wrapped; otherwise wrap SHALL be 0.
REQ-019 A direction change takes effect on the same edge; no pipeline latency; count latency from en to update is 1 cycle.
REQ-020 count SHALL never hold a value >= MODULUS, in any reachable state.
REQ-021 Arithmetic SHALL be WIDTH bits; with MODULUS == 2**WIDTH, wrap is the natural overflow and behaviour matches REQ-014/015.
REQ-022 Cascading: tc of one instance driving en of the next SHALL form a multi-digit counter with no extra logic.

Reset
REQ-023 On rst=1, count SHALL become 0 and wrap SHALL become 0 immediately, regardless of clk.
REQ-024 Reset asserted mid-count SHALL abort the count; after rst falls, the first enabled edge SHALL move count from 0 per REQ-014/015.
REQ-025 While rst=1, tc SHALL follow REQ-017 using count=0 (high when en=1, load=0, up_dn=0).

Configuration
REQ-026 Macro MODN_SAT_EN SHALL select saturating mode when defined.
REQ-027 With MODN_SAT_EN defined: up at MODULUS-1 and down at 0 SHALL hold count, tc SHALL still assert per REQ-017, and wrap SHALL stay 0.
REQ-028 Without MODN_SAT_EN: wrap-around behaviour per REQ-014/015/018 applies.

Verification (WIDTH=4, MODULUS=10, macro undefined unless stated)
REQ-029 Reset test: rst pulse with no clk edge -> count=0, wrap=0; en=1 up for 12 edges -> count 1..9,0,1,2; tc high at count=9; wrap pulse after the 10th edge.
REQ-030 Down test: from reset, en=1, up_dn=0 -> tc=1 at count=0; next edge count=9; wrap=1 one cycle; then 8,7.
REQ-031 Load test: load_val=7 with load=1, en=1 -> count=7, no wrap; load_val=13 -> count=9 (clamped); load overrides a count of 9 going up (no wrap, tc=0).
REQ-032 Mid-operation reset: count=6, assert rst between edges -> count=0 asynchronously; hold en=1 through reset release -> first edge gives 1.
REQ-033 Cascade test: two instances, low tc -> high en; 100 up edges from 00 -> reads 99 then 00, high-digit wrap pulses once.
REQ-034 MODN_SAT_EN defined: 15 up edges from 0 -> count sticks at 9, tc=1, wrap never 1; 12 down edges -> count sticks at 0.
